mmio_round_robin_arbiter: RTL and testbench
===========================================

# mmio_round_robin_arbiter

Two-requester arbiter that shares the single MMIO host port of the system memory mapper between the off-chip host link and an on-chip configuration loader. Read and write channels are arbitrated independently with round-robin fairness. A grant is held until the downstream device acks or a watchdog expires. The block sits directly upstream of the system mapper's device port.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: cycles a granted transaction may wait for a downstream ack before forced completion; legal range 2..65535.
- TIMEOUT_READ_DATA, 32'hDEAD_BEEF: read data returned on a timed-out read.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- requester_0  mmio_if.device  —  higher-priority-after-reset requester (host link).
- requester_1  mmio_if.device  —  second requester (configuration loader).
- mapped_interface  mmio_if.host  —  single port toward the system mapper.
- timeout_count  output  16  saturating count of watchdog-forced completions, both channels.

Each channel carries the standard mmio_if fields: req, index, data, ack, at the widths the interface defines.

## Operation
- Two identical, independent channel FSMs: read and write. Each has states IDLE, GRANT_0 and GRANT_1, plus a last_grant bit.
- IDLE: all downstream req/index/data are driven 0, and all acks to requesters are 0.
  - If exactly one requester asserts req, go to that requester's GRANT state.
  - If both assert req, grant the requester that is not last_grant.
- GRANT_n: forward requester n's req, index and (write) data to mapped_interface combinationally. Forward mapped_interface ack (and read_data) to requester n only. The other requester sees ack=0 and read_data=0.
- Leaving GRANT_n, triggered by either event below:
  - mapped ack=1: return to IDLE, set last_grant=n.
  - Watchdog reaches TIMEOUT_CYCLES-1 with no ack: for one cycle, drive ack=1 to requester n (read_data=TIMEOUT_READ_DATA on reads) and force downstream req=0. Return to IDLE, set last_grant=n, increment timeout_count (saturating at 16'hFFFF).
- Requester withdraws req while granted (protocol violation): return to IDLE the next cycle, do not update last_grant, drive no ack.
- Watchdog: per-channel counter. Cleared in IDLE, increments each GRANT cycle without ack.
- If both channels time out in the same cycle, timeout_count increments by 2 (saturating).
- Requesters must hold req, index and data stable until they see ack. Ack is a one-cycle pulse.

## Timing
- Reset values:
  - Both FSMs in IDLE.
  - last_grant=1, so requester_0 wins the first contention.
  - Watchdogs and timeout_count are 0.
  - All outputs to requesters and to mapped_interface are 0.
- Reset asserted mid-transaction: the FSM is in IDLE after the edge. Downstream req drops in the cycle after reset is sampled, and no ack is issued for the aborted transaction.
- Latency:
  - Req seen in IDLE at cycle t, so the grant state is registered at t+1 and downstream req is asserted in t+1.
  - A combinational downstream ack in t+1 reaches the requester in t+1.
  - The FSM is in IDLE at t+2, and the next grant is at t+3 at the earliest. Peak rate is one transaction per 2 cycles per channel.
- Timed-out transaction: the forced ack appears in cycle t+TIMEOUT_CYCLES.
- A read and a write may be in flight simultaneously, from the same or different requesters.

## Test plan
- Single read from requester_0 to index 0x40000000 with a device acking in the same cycle → downstream read_req in cycle 1 after req, requester_0 read_ack and data in that same cycle, requester_1 sees ack=0 throughout.
- Both requesters continuously request writes to distinct indices, 6 transactions → grants alternate 0,1,0,1,0,1 starting with requester_0, and each downstream write_data matches the granted requester.
- Device never acks, TIMEOUT_CYCLES=8, read from requester_1 → ack to requester_1 exactly 8 cycles after req with read_data=32'hDEADBEEF, downstream read_req low during that cycle, timeout_count=1.
- Simultaneous read by requester_0 and write by requester_1, device acks both in the same cycle → both complete in cycle 1 with no cross-talk, and both channels are IDLE in cycle 2.
- Reset pulsed while requester_0 holds a granted write waiting for ack → no ack issued, downstream write_req is 0 the cycle after reset, and after reset requester_0 wins the next contention.
- Force timeout_count to 16'hFFFE, then time out reads and writes together → count saturates at 16'hFFFF.

Source files
------------

// File: rtl/mmio_round_robin_arbiter_if.sv
// MMIO port bundle: independent read and write request/ack channels.
interface mmio_if #(
  parameter int unsigned INDEX_W = 32,
  parameter int unsigned DATA_W  = 32
);
  logic              read_req;
  logic [INDEX_W-1:0] read_index;
  logic [DATA_W-1:0]  read_data;
  logic              read_ack;
  logic              write_req;
  logic [INDEX_W-1:0] write_index;
  logic [DATA_W-1:0]  write_data;
  logic              write_ack;

  // Side that issues transactions.
  modport host (
    output read_req, read_index,
    input  read_data, read_ack,
    output write_req, write_index, write_data,
    input  write_ack
  );

  // Side that services transactions.
  modport device (
    input  read_req, read_index,
    output read_data, read_ack,
    input  write_req, write_index, write_data,
    output write_ack
  );
endinterface

// File: rtl/mmio_round_robin_arbiter.sv
// Two-requester round-robin arbiter in front of the system mapper's MMIO port.
// Read and write channels arbitrate independently; a grant is held until the
// device acks, the requester withdraws, or the per-channel watchdog expires.
module mmio_round_robin_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES    = 1024,
  parameter logic [31:0] TIMEOUT_READ_DATA = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset,
  mmio_if.device      requester_0,
  mmio_if.device      requester_1,
  mmio_if.host        mapped_interface,
  output logic [15:0] timeout_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_0 = 2'd1,
    GRANT_1 = 2'd2
  } chan_state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  chan_state_t rd_state_q, rd_state_d;
  chan_state_t wr_state_q, wr_state_d;
  logic        rd_last_q, rd_last_d;
  logic        wr_last_q, wr_last_d;
  logic [15:0] rd_wd_q, rd_wd_d;
  logic [15:0] wr_wd_q, wr_wd_d;
  logic        rd_expire, wr_expire;
  logic        rd_timeout, wr_timeout;
  logic [15:0] count_d;

  // Watchdog is 0 in IDLE and WD_LAST >= 1, so expiry only ever hits a granted channel.
  assign rd_expire = (rd_wd_q == WD_LAST);
  assign wr_expire = (wr_wd_q == WD_LAST);

  // State, fairness and watchdog registers for both channels plus the timeout counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q    <= IDLE;
      wr_state_q    <= IDLE;
      rd_last_q     <= 1'b1;
      wr_last_q     <= 1'b1;
      rd_wd_q       <= '0;
      wr_wd_q       <= '0;
      timeout_count <= '0;
    end else begin
      rd_state_q    <= rd_state_d;
      wr_state_q    <= wr_state_d;
      rd_last_q     <= rd_last_d;
      wr_last_q     <= wr_last_d;
      rd_wd_q       <= rd_wd_d;
      wr_wd_q       <= wr_wd_d;
      timeout_count <= count_d;
    end
  end

  // Saturating add of this cycle's forced completions (0, 1 or 2).
  always_comb begin
    logic [16:0] sum;
    sum     = {1'b0, timeout_count} + 17'(rd_timeout) + 17'(wr_timeout);
    count_d = sum[16] ? 16'hFFFF : sum[15:0];
  end

  // Read request path toward the mapper; kept apart from the ack path so a
  // combinational device ack does not loop back into this block.
  always_comb begin
    mapped_interface.read_req   = 1'b0;
    mapped_interface.read_index = '0;
    if (!rd_expire) begin
      case (rd_state_q)
        GRANT_0: begin
          mapped_interface.read_req   = requester_0.read_req;
          mapped_interface.read_index = requester_0.read_index;
        end
        GRANT_1: begin
          mapped_interface.read_req   = requester_1.read_req;
          mapped_interface.read_index = requester_1.read_index;
        end
        default: ;
      endcase
    end
  end

  // Read channel: arbitration, ack/data return and next-state.
  always_comb begin
    rd_state_d            = rd_state_q;
    rd_last_d             = rd_last_q;
    rd_wd_d               = '0;
    rd_timeout            = 1'b0;
    requester_0.read_ack  = 1'b0;
    requester_0.read_data = '0;
    requester_1.read_ack  = 1'b0;
    requester_1.read_data = '0;
    case (rd_state_q)
      IDLE: begin
        if (requester_0.read_req && (!requester_1.read_req || rd_last_q))
          rd_state_d = GRANT_0;
        else if (requester_1.read_req)
          rd_state_d = GRANT_1;
      end
      GRANT_0: begin
        if (!requester_0.read_req) begin
          rd_state_d = IDLE;
        end else if (rd_expire) begin
          requester_0.read_ack  = 1'b1;
          requester_0.read_data = TIMEOUT_READ_DATA;
          rd_timeout            = 1'b1;
          rd_state_d            = IDLE;
          rd_last_d             = 1'b0;
        end else if (mapped_interface.read_ack) begin
          requester_0.read_ack  = 1'b1;
          requester_0.read_data = mapped_interface.read_data;
          rd_state_d            = IDLE;
          rd_last_d             = 1'b0;
        end else begin
          rd_wd_d = rd_wd_q + 16'd1;
        end
      end
      GRANT_1: begin
        if (!requester_1.read_req) begin
          rd_state_d = IDLE;
        end else if (rd_expire) begin
          requester_1.read_ack  = 1'b1;
          requester_1.read_data = TIMEOUT_READ_DATA;
          rd_timeout            = 1'b1;
          rd_state_d            = IDLE;
          rd_last_d             = 1'b1;
        end else if (mapped_interface.read_ack) begin
          requester_1.read_ack  = 1'b1;
          requester_1.read_data = mapped_interface.read_data;
          rd_state_d            = IDLE;
          rd_last_d             = 1'b1;
        end else begin
          rd_wd_d = rd_wd_q + 16'd1;
        end
      end
      default: rd_state_d = IDLE;
    endcase
  end

  // Write request path toward the mapper.
  always_comb begin
    mapped_interface.write_req   = 1'b0;
    mapped_interface.write_index = '0;
    mapped_interface.write_data  = '0;
    if (!wr_expire) begin
      case (wr_state_q)
        GRANT_0: begin
          mapped_interface.write_req   = requester_0.write_req;
          mapped_interface.write_index = requester_0.write_index;
          mapped_interface.write_data  = requester_0.write_data;
        end
        GRANT_1: begin
          mapped_interface.write_req   = requester_1.write_req;
          mapped_interface.write_index = requester_1.write_index;
          mapped_interface.write_data  = requester_1.write_data;
        end
        default: ;
      endcase
    end
  end

  // Write channel: arbitration, ack return and next-state.
  always_comb begin
    wr_state_d            = wr_state_q;
    wr_last_d             = wr_last_q;
    wr_wd_d               = '0;
    wr_timeout            = 1'b0;
    requester_0.write_ack = 1'b0;
    requester_1.write_ack = 1'b0;
    case (wr_state_q)
      IDLE: begin
        if (requester_0.write_req && (!requester_1.write_req || wr_last_q))
          wr_state_d = GRANT_0;
        else if (requester_1.write_req)
          wr_state_d = GRANT_1;
      end
      GRANT_0: begin
        if (!requester_0.write_req) begin
          wr_state_d = IDLE;
        end else if (wr_expire) begin
          requester_0.write_ack = 1'b1;
          wr_timeout            = 1'b1;
          wr_state_d            = IDLE;
          wr_last_d             = 1'b0;
        end else if (mapped_interface.write_ack) begin
          requester_0.write_ack = 1'b1;
          wr_state_d            = IDLE;
          wr_last_d             = 1'b0;
        end else begin
          wr_wd_d = wr_wd_q + 16'd1;
        end
      end
      GRANT_1: begin
        if (!requester_1.write_req) begin
          wr_state_d = IDLE;
        end else if (wr_expire) begin
          requester_1.write_ack = 1'b1;
          wr_timeout            = 1'b1;
          wr_state_d            = IDLE;
          wr_last_d             = 1'b1;
        end else if (mapped_interface.write_ack) begin
          requester_1.write_ack = 1'b1;
          wr_state_d            = IDLE;
          wr_last_d             = 1'b1;
        end else begin
          wr_wd_d = wr_wd_q + 16'd1;
        end
      end
      default: wr_state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_round_robin_arbiter.sv
// Scoreboard bench for mmio_round_robin_arbiter (TIMEOUT_CYCLES=8).
module tb_mmio_round_robin_arbiter;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] data;
  } dw_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] tcount;
  logic        rd_en, wr_en;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  exp_t q_r0[$], q_r1[$], q_w0[$], q_w1[$];
  dw_t  q_dw[$];
  exp_t er;
  dw_t  ed;

  mmio_if r0();
  mmio_if r1();
  mmio_if m();

  mmio_round_robin_arbiter #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_READ_DATA(32'hDEAD_BEEF)
  ) dut (
    .clock(clk),
    .reset(reset),
    .requester_0(r0),
    .requester_1(r1),
    .mapped_interface(m),
    .timeout_count(tcount)
  );

  // Device model: acks combinationally when enabled, read data is ~index.
  assign m.read_ack  = m.read_req & rd_en;
  assign m.read_data = ~m.read_index;
  assign m.write_ack = m.write_req & wr_en;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] wdat(input logic [31:0] idx);
    return idx ^ 32'hA5A5_0000;
  endfunction

  task automatic drive(input bit wr, input bit who, input bit req, input logic [31:0] idx);
    case ({wr, who})
      2'b00: begin r0.read_req = req; r0.read_index = idx; end
      2'b01: begin r1.read_req = req; r1.read_index = idx; end
      2'b10: begin r0.write_req = req; r0.write_index = idx; r0.write_data = wdat(idx); end
      default: begin r1.write_req = req; r1.write_index = idx; r1.write_data = wdat(idx); end
    endcase
  endtask

  function automatic bit acked(input bit wr, input bit who);
    case ({wr, who})
      2'b00:   return r0.read_ack;
      2'b01:   return r1.read_ack;
      2'b10:   return r0.write_ack;
      default: return r1.write_ack;
    endcase
  endfunction

  // Requester agent: n back-to-back transactions, expected ack pushed on issue.
  task automatic agent(input bit wr, input bit who, input int n, input logic [31:0] base,
                       input int first_lat, input int lat, input bit to);
    logic [31:0] idx;
    exp_t e;
    bit got;
    int k;
    for (int i = 0; i < n; i++) begin
      idx = base + 32'(i * 4);
      drive(wr, who, 1'b1, idx);
      e.data = to ? 32'hDEAD_BEEF : (wr ? 32'h0 : ~idx);
      e.cyc  = cyc + ((i == 0) ? first_lat : lat);
      case ({wr, who})
        2'b00:   q_r0.push_back(e);
        2'b01:   q_r1.push_back(e);
        2'b10:   q_w0.push_back(e);
        default: q_w1.push_back(e);
      endcase
      got = 1'b0;
      k = 0;
      while (!got && k < 64) begin
        @(negedge clk);
        k++;
        got = acked(wr, who);
      end
      if (!got) check("agent_ack_wait", 32'(got), 32'd1);
      @(posedge clk);
      #1;
    end
    drive(wr, who, 1'b0, '0);
  endtask

  task automatic push_dw(input logic [31:0] idx);
    dw_t d;
    d.idx = idx;
    d.data = wdat(idx);
    q_dw.push_back(d);
  endtask

  // Monitor: pops expectations when acks or downstream writes appear.
  always @(negedge clk) begin
    if (r0.read_ack) begin
      if (q_r0.size() == 0) check("r0_rack_unexp", 32'(r0.read_ack), 32'd0);
      else begin
        er = q_r0.pop_front();
        check("r0_rdata", r0.read_data, er.data);
        check("r0_rcyc", 32'(cyc), 32'(er.cyc));
      end
    end else check("r0_rdata_idle", r0.read_data, 32'd0);
    if (r1.read_ack) begin
      if (q_r1.size() == 0) check("r1_rack_unexp", 32'(r1.read_ack), 32'd0);
      else begin
        er = q_r1.pop_front();
        check("r1_rdata", r1.read_data, er.data);
        check("r1_rcyc", 32'(cyc), 32'(er.cyc));
      end
    end else check("r1_rdata_idle", r1.read_data, 32'd0);
    if (r0.write_ack) begin
      if (q_w0.size() == 0) check("r0_wack_unexp", 32'(r0.write_ack), 32'd0);
      else begin
        er = q_w0.pop_front();
        check("r0_wcyc", 32'(cyc), 32'(er.cyc));
      end
    end
    if (r1.write_ack) begin
      if (q_w1.size() == 0) check("r1_wack_unexp", 32'(r1.write_ack), 32'd0);
      else begin
        er = q_w1.pop_front();
        check("r1_wcyc", 32'(cyc), 32'(er.cyc));
      end
    end
    if (m.write_req && m.write_ack) begin
      if (q_dw.size() == 0) check("dw_unexp", 32'(m.write_req), 32'd0);
      else begin
        ed = q_dw.pop_front();
        check("dw_index", m.write_index, ed.idx);
        check("dw_data", m.write_data, ed.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, '0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dreq_rd", 32'(m.read_req), 32'd0);
    check("rst_dreq_wr", 32'(m.write_req), 32'd0);
    check("rst_r0_wack", 32'(r0.write_ack), 32'd0);
    check("rst_r1_wack", 32'(r1.write_ack), 32'd0);
    check("rst_tcount", 32'(tcount), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single read from requester_0, device acks in the same cycle
    rd_en = 1'b1;
    fork
      agent(1'b0, 1'b0, 1, 32'h4000_0000, 1, 1, 1'b0);
      begin
        repeat (2) @(negedge clk);
        check("t1_dreq", 32'(m.read_req), 32'd1);
        check("t1_didx", m.read_index, 32'h4000_0000);
      end
    join

    // Write contention: grants alternate 0,1,0,1,0,1
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_dw(32'h1000 + 32'(i * 4));
      push_dw(32'h2000 + 32'(i * 4));
    end
    fork
      agent(1'b1, 1'b0, 3, 32'h1000, 1, 3, 1'b0);
      agent(1'b1, 1'b1, 3, 32'h2000, 3, 3, 1'b0);
    join

    // Read timeout on requester_1
    rd_en = 1'b0;
    fork
      agent(1'b0, 1'b1, 1, 32'h0000_0800, 8, 8, 1'b1);
      begin
        repeat (8) @(negedge clk);
        check("t3_dreq_before", 32'(m.read_req), 32'd1);
        @(negedge clk);
        check("t3_dreq_forced", 32'(m.read_req), 32'd0);
      end
    join
    check("t3_tcount", 32'(tcount), 32'd1);

    // Concurrent read (r0) and write (r1), both acked in the same cycle
    rd_en = 1'b1;
    wr_en = 1'b1;
    push_dw(32'h4000);
    fork
      agent(1'b0, 1'b0, 1, 32'h3000, 1, 1, 1'b0);
      agent(1'b1, 1'b1, 1, 32'h4000, 1, 1, 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("t4_idle_rd", 32'(m.read_req), 32'd0);
        check("t4_idle_wr", 32'(m.write_req), 32'd0);
      end
    join

    // Reset mid-write: leave write last_grant at 0 first
    push_dw(32'h7000);
    agent(1'b1, 1'b0, 1, 32'h7000, 1, 1, 1'b0);
    wr_en = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h7100);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h7200);
    @(negedge clk);
    check("t5_dreq_granted", 32'(m.write_req), 32'd1);
    @(posedge clk);
    #1;
    check("t5_dreq_after_rst", 32'(m.write_req), 32'd0);
    check("t5_r0_noack", 32'(r0.write_ack), 32'd0);
    check("t5_tcount_rst", 32'(tcount), 32'd0);
    reset = 1'b0;
    wr_en = 1'b1;
    push_dw(32'h7100);
    push_dw(32'h7200);
    fork
      agent(1'b1, 1'b0, 1, 32'h7100, 1, 1, 1'b0);
      agent(1'b1, 1'b1, 1, 32'h7200, 3, 3, 1'b0);
    join

    // Simultaneous read and write timeouts count twice
    rd_en = 1'b0;
    wr_en = 1'b0;
    fork
      agent(1'b0, 1'b0, 1, 32'h5000, 8, 8, 1'b1);
      agent(1'b1, 1'b1, 1, 32'h6000, 8, 8, 1'b1);
    join
    check("t6_tcount_two", 32'(tcount), 32'd2);

    // Saturation from 16'hFFFE
    force dut.timeout_count = 16'hFFFE;
    #2;
    release dut.timeout_count;
    #1;
    check("t6_tcount_preload", 32'(tcount), 32'h0000_FFFE);
    @(posedge clk);
    #1;
    fork
      agent(1'b0, 1'b0, 1, 32'h5100, 8, 8, 1'b1);
      agent(1'b1, 1'b1, 1, 32'h6100, 8, 8, 1'b1);
    join
    check("t6_tcount_sat", 32'(tcount), 32'h0000_FFFF);
    agent(1'b0, 1'b1, 1, 32'h5200, 8, 8, 1'b1);
    check("t6_tcount_hold", 32'(tcount), 32'h0000_FFFF);

    repeat (2) @(posedge clk);
    #1;
    check("left_r0", 32'(q_r0.size()), 32'd0);
    check("left_r1", 32'(q_r1.size()), 32'd0);
    check("left_w0", 32'(q_w0.size()), 32'd0);
    check("left_w1", 32'(q_w1.size()), 32'd0);
    check("left_dw", 32'(q_dw.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
